// File: rtl/fakeregfile_128x64_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fakeregfile_128x64_arb                                          |
// | Two-requester valid/ready arbiter in front of a single-port regfile with |
// | one-cycle read latency; per-requester response slot plus one skid entry. |
// | Option : FAKEREGFILE_ARB_RR_EN = round-robin, otherwise fixed priority.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fakeregfile_128x64_arb #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*BITS-1:0]       req_wd,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [2*BITS-1:0]       rsp_data,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BITS-1:0]         mem_wd,
  input  logic [BITS-1:0]         mem_rd
);

  logic       r_infl_v;
  logic       r_infl_tag;
  logic [1:0] w_rsp_v;
  logic [1:0] w_skid_v;
  logic [1:0] w_land;
  logic [1:0] w_drain;
  logic [1:0] w_elig;
  logic [1:0] w_gnt;
  logic       w_sel;

  assign w_land  = r_infl_v ? (r_infl_tag ? 2'b10 : 2'b01) : 2'b00;
  assign w_drain = w_rsp_v & rsp_ready;

  // A read may issue while an earlier one is still in flight only if the
  // consumer is draining now; the skid entry absorbs a later stall.
  assign w_elig = {2{~rst}} & req_valid &
                  (req_we | (~w_skid_v & (rsp_ready | (~w_rsp_v & ~w_land))));

`ifdef FAKEREGFILE_ARB_RR_EN
  logic r_ptr;

  always_comb begin
    w_gnt = 2'b00;
    if (w_elig[r_ptr]) begin
      w_gnt[r_ptr] = 1'b1;
    end else if (w_elig[~r_ptr]) begin
      w_gnt[~r_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (|w_gnt) begin
      r_ptr <= w_gnt[0];
    end
  end
`else
  always_comb begin
    w_gnt = 2'b00;
    if (w_elig[0]) begin
      w_gnt[0] = 1'b1;
    end else if (w_elig[1]) begin
      w_gnt[1] = 1'b1;
    end
  end
`endif

  assign req_ready = w_gnt;
  assign w_sel     = w_gnt[1];
  assign mem_ce    = |w_gnt;
  assign mem_we    = mem_ce & req_we[w_sel];
  assign mem_addr  = ~mem_ce ? '0 :
                     (w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0]);
  assign mem_wd    = ~mem_ce ? '0 :
                     (w_sel ? req_wd[2*BITS-1:BITS] : req_wd[BITS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_infl_v   <= 1'b0;
      r_infl_tag <= 1'b0;
    end else begin
      r_infl_v   <= mem_ce & ~mem_we;
      r_infl_tag <= w_sel;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic            r_v;
      logic            r_sv;
      logic [BITS-1:0] r_d;
      logic [BITS-1:0] r_sd;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v  <= 1'b0;
          r_sv <= 1'b0;
        end else if (r_sv) begin
          if (w_drain[gi]) r_sv <= 1'b0;
        end else if (w_land[gi]) begin
          if (r_v && !w_drain[gi]) r_sv <= 1'b1;
          else                     r_v  <= 1'b1;
        end else if (w_drain[gi]) begin
          r_v <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (r_sv) begin
          if (w_drain[gi]) r_d <= r_sd;
        end else if (w_land[gi]) begin
          if (r_v && !w_drain[gi]) r_sd <= mem_rd;
          else                     r_d  <= mem_rd;
        end
      end

      assign w_rsp_v[gi]                 = r_v;
      assign w_skid_v[gi]                = r_sv;
      assign rsp_data[gi*BITS +: BITS]   = r_d;
    end
  endgenerate

  assign rsp_valid = w_rsp_v;

endmodule
`default_nettype wire

// File: tb/tb_fakeregfile_128x64_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fakeregfile_128x64_arb                                       |
// | Directed vector table plus random traffic against a queue-based model.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fakeregfile_128x64_arb;

`ifdef FAKEREGFILE_ARB_RR_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [13:0]  req_addr;
  logic [127:0] req_wd, rsp_data;
  logic         mem_ce, mem_we;
  logic [6:0]   mem_addr;
  logic [63:0]  mem_wd, mem_rd;

  logic [63:0]  mem [128];
  logic [63:0]  shadow [128];
  logic [63:0]  q0[$];
  logic [63:0]  q1[$];
  logic [1:0]   hold, prev_gnt;
  logic [63:0]  held [2];
  int           checks = 0;
  int           errors = 0;
  int           nrd = 0;

  always #5 clk = ~clk;

  fakeregfile_128x64_arb #(.BITS(64), .ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Regfile environment: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr] = mem_wd;
      else        mem_rd <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       r;
    logic [1:0] v, we;
    logic [6:0] a0, a1;
    logic [63:0] d1;
    logic [1:0] rr, e_rdy;
    logic       e_ce;
    logic [6:0] e_a;
    logic [1:0] e_rv;
    logic [63:0] e_d0, e_d1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(logic r, logic [1:0] v, logic [1:0] we, logic [6:0] a0,
                             logic [6:0] a1, logic [63:0] d1, logic [1:0] rr,
                             logic [1:0] e_rdy, logic e_ce, logic [6:0] e_a,
                             logic [1:0] e_rv, logic [63:0] e_d0, logic [63:0] e_d1);
    vec_t t;
    t.r = r; t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d1 = d1; t.rr = rr;
    t.e_rdy = e_rdy; t.e_ce = e_ce; t.e_a = e_a; t.e_rv = e_rv; t.e_d0 = e_d0; t.e_d1 = e_d1;
    return t;
  endfunction

  task automatic rand_cycle(input bit idle);
    int g;
    logic [6:0] a;
    logic [63:0] e;
    bit have;
    @(negedge clk);
    if (idle) begin
      req_valid = 2'b00;
      rsp_ready = 2'b11;
    end else begin
      req_valid = 2'($urandom);
      req_we    = 2'($urandom);
      req_addr  = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      req_wd    = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = {($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3)};
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hold[i]) begin
        chk("stable_valid", 128'(rsp_valid[i]), 128'(1));
        chk("stable_data", 128'(rsp_data[i*64 +: 64]), 128'(held[i]));
      end
      if (rsp_valid[i] && rsp_ready[i]) begin
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        chk("rsp_expected", 128'(have), 128'(1));
        if (have) begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("rsp_data", 128'(rsp_data[i*64 +: 64]), 128'(e));
        end
      end
    end
    chk("onehot", 128'($onehot0(req_ready)), 128'(1));
    chk("ready_subset", 128'(req_ready & ~req_valid), 128'(0));
    chk("mem_ce", 128'(mem_ce), 128'(|req_ready));
    if (|(req_valid & req_we)) chk("write_granted", 128'(mem_ce), 128'(1));
    if (c_RR) begin
      if (&(req_valid & req_we) && |prev_gnt) chk("rr_alt", 128'(req_ready), 128'(~prev_gnt));
    end else begin
      if (req_valid[0] && req_we[0]) chk("fixed_prio", 128'(req_ready[0]), 128'(1));
    end
    if (|req_ready) begin
      g = int'(req_ready[1]);
      a = req_addr[g*7 +: 7];
      chk("mem_we", 128'(mem_we), 128'(req_we[g]));
      chk("mem_addr", 128'(mem_addr), 128'(a));
      if (req_we[g]) begin
        chk("mem_wd", 128'(mem_wd), 128'(req_wd[g*64 +: 64]));
        shadow[a] = req_wd[g*64 +: 64];
      end else begin
        nrd++;
        if (g == 0) q0.push_back(shadow[a]);
        else        q1.push_back(shadow[a]);
      end
    end
    hold     = rsp_valid & ~rsp_ready;
    held[0]  = rsp_data[63:0];
    held[1]  = rsp_data[127:64];
    prev_gnt = req_ready;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'(i) * 64'h0101;
    mem[5] = 64'hA5; mem[1] = 64'h11; mem[2] = 64'h22; mem[6] = 64'h66; mem[7'h7F] = 64'h77;
    mem_rd = '0;
    rst = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wd = '0; rsp_ready = 2'b11;
    repeat (2) @(posedge clk);

    //          r  v      we     a0     a1     d1        rr     rdy              ce  ea                rv               d0     d1
    vt.push_back(V(1, 2'b11, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(1, 2'b11, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h05, 7'h00, 64'h0,    2'b11, 2'b01,           1, 7'h05,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b01,           64'hA5, 64'h0));
    vt.push_back(V(0, 2'b10, 2'b10, 7'h00, 7'h10, 64'h1234, 2'b11, 2'b10,           1, 7'h10,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b11, 2'b00, 7'h01, 7'h02, 64'h0,    2'b11, 2'b01,           1, 7'h01,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b11, 2'b00, 7'h01, 7'h02, 64'h0,    2'b11, c_RR ? 2'b10 : 2'b01, 1, c_RR ? 7'h02 : 7'h01, 2'b00, 64'h0, 64'h0));
    vt.push_back(V(0, 2'b11, 2'b00, 7'h01, 7'h02, 64'h0,    2'b11, 2'b01,           1, 7'h01,            2'b01,           64'h11, 64'h22));
    vt.push_back(V(0, 2'b11, 2'b00, 7'h01, 7'h02, 64'h0,    2'b11, c_RR ? 2'b10 : 2'b01, 1, c_RR ? 7'h02 : 7'h01, c_RR ? 2'b10 : 2'b01, 64'h11, 64'h22));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b01,           64'h11, 64'h22));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            c_RR ? 2'b10 : 2'b01, 64'h11, 64'h22));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h05, 7'h00, 64'h0,    2'b00, 2'b01,           1, 7'h05,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b11, 2'b10, 7'h06, 7'h40, 64'hBEEF, 2'b00, 2'b10,           1, 7'h40,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h06, 7'h00, 64'h0,    2'b00, 2'b00,           0, 7'h00,            2'b01,           64'hA5, 64'h0));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h06, 7'h00, 64'h0,    2'b00, 2'b00,           0, 7'h00,            2'b01,           64'hA5, 64'h0));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h06, 7'h00, 64'h0,    2'b01, 2'b01,           1, 7'h06,            2'b01,           64'hA5, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b01, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b01,           64'h66, 64'h0));
    vt.push_back(V(0, 2'b10, 2'b10, 7'h00, 7'h7F, 64'hFF,   2'b11, 2'b10,           1, 7'h7F,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b10, 2'b00, 7'h00, 7'h7F, 64'h0,    2'b11, 2'b10,           1, 7'h7F,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b10,           64'h0, 64'hFF));
    vt.push_back(V(0, 2'b01, 2'b00, 7'h05, 7'h00, 64'h0,    2'b11, 2'b01,           1, 7'h05,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(1, 2'b11, 2'b00, 7'h05, 7'h05, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));
    vt.push_back(V(0, 2'b00, 2'b00, 7'h00, 7'h00, 64'h0,    2'b11, 2'b00,           0, 7'h00,            2'b00,           64'h0, 64'h0));

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      rst = vt[k].r; req_valid = vt[k].v; req_we = vt[k].we;
      req_addr = {vt[k].a1, vt[k].a0}; req_wd = {vt[k].d1, 64'h0}; rsp_ready = vt[k].rr;
      #1;
      chk($sformatf("row%0d_req_ready", k), 128'(req_ready), 128'(vt[k].e_rdy));
      chk($sformatf("row%0d_mem_ce", k), 128'(mem_ce), 128'(vt[k].e_ce));
      if (vt[k].e_ce) chk($sformatf("row%0d_mem_addr", k), 128'(mem_addr), 128'(vt[k].e_a));
      chk($sformatf("row%0d_rsp_valid", k), 128'(rsp_valid), 128'(vt[k].e_rv));
      if (vt[k].e_rv[0]) chk($sformatf("row%0d_rsp_data0", k), 128'(rsp_data[63:0]), 128'(vt[k].e_d0));
      if (vt[k].e_rv[1]) chk($sformatf("row%0d_rsp_data1", k), 128'(rsp_data[127:64]), 128'(vt[k].e_d1));
    end

    for (int i = 0; i < 128; i++) shadow[i] = mem[i];
    hold = 2'b00; prev_gnt = 2'b00;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 8; c++) rand_cycle(1'b1);
    chk("q0_empty", 128'(q0.size()), 128'(0));
    chk("q1_empty", 128'(q1.size()), 128'(0));
    chk("final_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reads_issued", 128'(nrd > 100), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
